// File: rtl/hc02_pkg.sv
// hc02_pkg: shared defaults and the debounce counter width helper for hc02 input conditioning.
package hc02_pkg;
  localparam int HC02_SYNC_STAGES_DEF     = 2;
  localparam int HC02_DEBOUNCE_CYCLES_DEF = 16;
  function automatic int hc02_cnt_w(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction
endpackage

// File: rtl/hc02_in_chan.sv
// hc02_in_chan: one input channel -- synchronizer, debounce counter, stable level and change pulse.
// Change pulse register exists only when HC02_IN_CHG_PULSE_EN is defined.
module hc02_in_chan
  import hc02_pkg::*;
#(
  parameter int SYNC_STAGES     = HC02_SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = HC02_DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic clean_o,
  output logic chg_o,
  output logic idle_o
);
  localparam int CW = hc02_cnt_w(DEBOUNCE_CYCLES);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_q, s_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   differs, accept;
  assign differs = sync_q[SYNC_STAGES-1] != s_q;
  assign accept  = differs && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
  always_comb begin
    s_d   = accept ? sync_q[SYNC_STAGES-1] : s_q;
    cnt_d = (differs && !accept) ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      s_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      s_q    <= s_d;
      cnt_q  <= cnt_d;
    end
  end
`ifdef HC02_IN_CHG_PULSE_EN
  logic chg_q;
  always_ff @(posedge clk) begin
    if (rst) chg_q <= 1'b0;
    else     chg_q <= accept;
  end
  assign chg_o = chg_q;
`else
  assign chg_o = 1'b0;
`endif
  assign clean_o = s_q;
  assign idle_o  = !differs && (cnt_q == '0);
endmodule

// File: rtl/hc02_in_cond.sv
// hc02_in_cond: synchronize and debounce pads A/B for the hc02 NOR core; flags when both are settled.
// Optional change pulses controlled by HC02_IN_CHG_PULSE_EN.
module hc02_in_cond
  import hc02_pkg::*;
#(
  parameter int SYNC_STAGES     = HC02_SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = HC02_DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_clean,
  output logic b_clean,
  output logic a_chg,
  output logic b_chg,
  output logic settled
);
  logic a_idle, b_idle, settled_q;
  hc02_in_chan #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_a (
    .clk(clk), .rst(rst), .raw_i(a_raw), .clean_o(a_clean), .chg_o(a_chg), .idle_o(a_idle)
  );
  hc02_in_chan #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_b (
    .clk(clk), .rst(rst), .raw_i(b_raw), .clean_o(b_clean), .chg_o(b_chg), .idle_o(b_idle)
  );
  always_ff @(posedge clk) begin
    if (rst) settled_q <= 1'b0;
    else     settled_q <= a_idle && b_idle;
  end
  assign settled = settled_q;
endmodule

// File: tb/tb_hc02_in_cond.sv
// tb_hc02_in_cond: random and directed pad stimulus scored against a run-length model of the debouncer.
module tb_hc02_in_cond;
  import hc02_pkg::*;
  localparam int SY = HC02_SYNC_STAGES_DEF;
  localparam int DB = HC02_DEBOUNCE_CYCLES_DEF;
`ifdef HC02_IN_CHG_PULSE_EN
  localparam bit CHG_EN = 1'b1;
`else
  localparam bit CHG_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, a_raw = 1'b0, b_raw = 1'b0;
  logic a_clean, b_clean, a_chg, b_chg, settled;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  hc02_in_cond dut (
    .clk(clk), .rst(rst), .a_raw(a_raw), .b_raw(b_raw),
    .a_clean(a_clean), .b_clean(b_clean), .a_chg(a_chg), .b_chg(b_chg), .settled(settled)
  );
  // Model: the level seen by the debouncer at edge e is the pad value sampled SY edges earlier,
  // or 0 if a reset occurred since; a level is accepted once it has differed for DB edges in a row.
  bit a_log[$], b_log[$];
  int last_rst = -1;
  bit cln[2], chg[2], st;
  int run[2];
  logic [4:0] exp_q[$];
  task automatic model_step();
    int e;
    bit sy[2];
    bit st_n;
    e = a_log.size();
    if (rst) begin
      last_rst = e;
      for (int c = 0; c < 2; c++) begin cln[c] = 0; chg[c] = 0; run[c] = 0; end
      st = 0;
    end else begin
      sy[0] = (e - SY > last_rst) ? a_log[e - SY] : 1'b0;
      sy[1] = (e - SY > last_rst) ? b_log[e - SY] : 1'b0;
      st_n = (sy[0] == cln[0]) && (run[0] == 0) && (sy[1] == cln[1]) && (run[1] == 0);
      for (int c = 0; c < 2; c++) begin
        chg[c] = 0;
        if (sy[c] != cln[c]) begin
          run[c]++;
          if (run[c] == DB) begin cln[c] = sy[c]; run[c] = 0; chg[c] = 1; end
        end else run[c] = 0;
      end
      st = st_n;
    end
    a_log.push_back(a_raw);
    b_log.push_back(b_raw);
    exp_q.push_back({cln[0], cln[1], chg[0] & CHG_EN, chg[1] & CHG_EN, st});
  endtask
  initial forever begin
    @(posedge clk);
    model_step();
  end
  initial forever begin
    logic [4:0] exp_v, got;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got = {a_clean, b_clean, a_chg, b_chg, settled};
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL outputs{a_clean,b_clean,a_chg,b_chg,settled} t=%0t got=%b exp=%b", $time, got, exp_v);
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic lat(input string nm, input int want);
    int n = 0;
    while (n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (a_clean === 1'b1) break;
    end
    checks++;
    if (n != want) begin
      failures++;
      $display("FAIL %s edges=%0d exp=%0d", nm, n, want);
    end
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    rst = 1; a_raw = 0; b_raw = 0;
    cyc(3);
    rst = 0;
    cyc(5);
    a_raw = 1;
    lat("lat_a", SY + DB);
    cyc(5);
    b_raw = 1; cyc(10); b_raw = 0; cyc(25);
    a_raw = 0; cyc(25);
    a_raw = 1; b_raw = 1; cyc(25);
    a_raw = 0; b_raw = 0; cyc(25);
    a_raw = 1; cyc(SY + 12);
    rst = 1; cyc(1);
    rst = 0;
    lat("lat_after_rst", SY + DB);
    cyc(5);
    repeat (60) begin
      rst = ($urandom_range(0, 19) == 0);
      a_raw = 1'($urandom);
      b_raw = 1'($urandom);
      cyc(1);
      rst = 0;
      cyc($urandom_range(0, 30));
    end
    cyc(3);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
